// File: rtl/sauria_addr_router.sv
// sauria_addr_router: steers one upstream request stream to the CFG, SRAMA,
// SRAMB or SRAMC target and returns responses in request order. A small tag
// FIFO records where each accepted request went. Unmapped addresses are
// answered locally with an error response and counted.
module sauria_addr_router #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic                  i_req_we,
  input  logic [DATA_W-1:0]     i_req_wdata,
  input  logic [DATA_W/8-1:0]   i_req_wstrb,
  output logic [3:0]            o_tgt_valid,
  input  logic [3:0]            i_tgt_ready,
  output logic [15:0]           o_tgt_addr,
  output logic                  o_tgt_we,
  output logic [DATA_W-1:0]     o_tgt_wdata,
  output logic [DATA_W/8-1:0]   o_tgt_wstrb,
  output logic [2:0]            o_cfg_sel,
  input  logic [3:0]            i_tgt_rsp_valid,
  output logic [3:0]            o_tgt_rsp_ready,
  input  logic [4*DATA_W-1:0]   i_tgt_rsp_rdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [7:0]            o_err_cnt
);

  localparam int PTR_W = $clog2(MAX_OUTST);
  localparam int CNT_W = PTR_W + 1;

  // Tag values double as the target index for the four real targets.
  typedef enum logic [2:0] {
    TAG_CFG   = 3'd0,
    TAG_SRAMA = 3'd1,
    TAG_SRAMB = 3'd2,
    TAG_SRAMC = 3'd3,
    TAG_ERR   = 3'd4
  } tag_t;

  tag_t             dec_tag;
  tag_t             fifo_mem [MAX_OUTST];
  tag_t             head;
  logic [1:0]       dec_idx;
  logic [1:0]       head_idx;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign o_tgt_we    = i_req_we;
  assign o_tgt_wdata = i_req_wdata;
  assign o_tgt_wstrb = i_req_wstrb;

  assign full     = (count == CNT_W'(MAX_OUTST));
  assign empty    = (count == '0);
  assign head     = fifo_mem[rd_ptr];
  assign dec_idx  = dec_tag[1:0];
  assign head_idx = head[1:0];
  assign push     = i_req_valid && o_req_ready;
  assign pop      = o_rsp_valid && i_rsp_ready;

  // Address decode: pick the target, config subregion and local offset.
  always_comb begin
    dec_tag    = TAG_ERR;
    o_cfg_sel  = 3'd0;
    o_tgt_addr = i_req_addr[15:0];
    if ((i_req_addr >> 20) == '0) begin
      case (i_req_addr[19:16])
        4'h0: begin
          if (i_req_addr[15:12] == 4'h0 && i_req_addr[11:9] <= 3'd4) begin
            dec_tag    = TAG_CFG;
            o_cfg_sel  = i_req_addr[11:9];
            o_tgt_addr = {7'b0, i_req_addr[8:0]};
          end
        end
        4'h1:    dec_tag = TAG_SRAMA;
        4'h2:    dec_tag = TAG_SRAMB;
        4'h3:    dec_tag = TAG_SRAMC;
        default: dec_tag = TAG_ERR;
      endcase
    end
  end

  // Request handshake: full blocks everything, errors need no target.
  always_comb begin
    o_tgt_valid = 4'b0000;
    o_req_ready = !full && (dec_tag == TAG_ERR || i_tgt_ready[dec_idx]);
    if (i_req_valid && !full && dec_tag != TAG_ERR) begin
      o_tgt_valid[dec_idx] = 1'b1;
    end
  end

  // Response steering from the FIFO head; only the head target may complete.
  always_comb begin
    o_rsp_valid     = 1'b0;
    o_rsp_rdata     = '0;
    o_rsp_err       = 1'b0;
    o_tgt_rsp_ready = 4'b0000;
    if (!empty) begin
      if (head == TAG_ERR) begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = 1'b1;
      end else begin
        o_rsp_valid               = i_tgt_rsp_valid[head_idx];
        o_rsp_rdata               = i_tgt_rsp_rdata[head_idx*DATA_W +: DATA_W];
        o_tgt_rsp_ready[head_idx] = i_rsp_ready;
      end
    end
  end

  // Tag storage has no reset; the count decides which entries are live.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= dec_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating count of accepted requests that hit no mapped region.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err_cnt <= 8'd0;
    end else if (push && dec_tag == TAG_ERR && o_err_cnt != 8'hFF) begin
      o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

endmodule

// File: doc/sauria_addr_router.md
Name: sauria_addr_router

Overview:
- Responder-side decoder for the SAURIA internal address space: config regions CFG_REGS/CON/ACT/WEI/OUT at 0x000/0x200/0x400/0x600/0x800, SRAMA at 0x1_0000, SRAMB at 0x2_0000, SRAMC at 0x3_0000, matched with SAURIA_MEM_ADDR_MASK and SAURIA_REG_ADDR_MASK.
- Takes one request stream from the configuration/DMA side and steers it to one of four targets: CFG, SRAMA, SRAMB, SRAMC.
- Tracks outstanding transactions and returns responses in request order.
- Answers unmapped addresses locally with an error.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width.
- MAX_OUTST, 4, maximum outstanding transactions (ID FIFO depth, power of 2, at least 2).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid&&ready.
- i_req_addr  in  ADDR_W  byte address.
- i_req_we  in  1  1 = write.
- i_req_wdata  in  DATA_W  write data.
- i_req_wstrb  in  DATA_W/8  byte strobes.
- o_tgt_valid  out  4  one-hot request valid; bit order {SRAMC, SRAMB, SRAMA, CFG}.
- i_tgt_ready  in  4  per-target request ready.
- o_tgt_addr  out  16  local offset.
- o_tgt_we, o_tgt_wdata, o_tgt_wstrb  out  1/DATA_W/DATA_W/8  broadcast copies of the request fields.
- o_cfg_sel  out  3  config subregion: 0=REGS, 1=CON, 2=ACT, 3=WEI, 4=OUT.
- i_tgt_rsp_valid  in  4  per-target response valid.
- o_tgt_rsp_ready  out  4  per-target response ready.
- i_tgt_rsp_rdata  in  4*DATA_W  per-target read data, target k in slice k.
- o_rsp_valid  out  1  upstream response valid.
- i_rsp_ready  in  1  upstream response ready.
- o_rsp_rdata  out  DATA_W  response data.
- o_rsp_err  out  1  decode error flag.
- o_err_cnt  out  8  saturating count of decode errors.

Behaviour:
- Decode is combinational on i_req_addr:
  - addr[31:20] != 0 -> ERR.
  - (addr & 0x000F_0000) == 0x0_0000 -> CFG region. Then (addr & 0x000F_FE00) of 0x000/0x200/0x400/0x600/0x800 -> CFG with o_cfg_sel 0..4. Any other value -> ERR.
  - (addr & 0x000F_0000) == 0x1_0000/0x2_0000/0x3_0000 -> SRAMA/SRAMB/SRAMC.
  - Any other value -> ERR.
- o_tgt_addr = addr[15:0] for SRAM targets; {7'b0, addr[8:0]} for CFG.
- o_tgt_valid[t] = i_req_valid && decode==t && !full. It is never asserted for ERR.
- o_req_ready = !full && (decode==ERR || i_tgt_ready[decode]).
- Full is evaluated on registered count only. No push-through when full, even if a pop happens the same cycle.
- Every accepted request, read or write, pushes its 3-bit tag (CFG/SRAMA/SRAMB/SRAMC/ERR) into the ID FIFO.
- Each target returns exactly one response per accepted request.
- Response path is combinational from the FIFO head H:
  - H = ERR: o_rsp_valid=1, o_rsp_rdata=0, o_rsp_err=1.
  - H = target t: o_rsp_valid = i_tgt_rsp_valid[t], o_rsp_rdata = slice t, o_rsp_err=0, o_tgt_rsp_ready[t] = i_rsp_ready.
  - All non-head o_tgt_rsp_ready bits = 0. Out-of-order target responses stall at the target until their tag reaches the head.
  - FIFO empty: o_rsp_valid=0 and all o_tgt_rsp_ready=0.
- Pop on o_rsp_valid && i_rsp_ready. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo MAX_OUTST.
- o_err_cnt increments on acceptance of an ERR request and saturates at 255.
- Reset (async assert, any time, including mid-transaction):
  - FIFO pointers and count = 0; o_err_cnt = 0.
  - Outputs therefore: o_req_ready follows decode/ready with empty FIFO; o_tgt_valid=0 unless a new request is present; o_rsp_valid=0; o_rsp_err=0; o_rsp_rdata=0.
  - In-flight transactions are discarded; the environment must reset targets together with the router.
- Latency: request is 0 cycles combinational to the target. Response is 0 cycles combinational from target to upstream. Minimum round trip is set by the target.

Test Plan:
- Read 0x0001_0040 with SRAMA answering 0xDEADBEEF after 2 cycles -> o_tgt_valid=4'b0010, o_tgt_addr=0x0040, then o_rsp_valid with rdata 0xDEADBEEF, err=0.
- Write 0x0000_0604 -> o_tgt_valid=4'b0001, o_cfg_sel=3, o_tgt_addr=0x004. Read 0x0000_0A00 -> accepted without any o_tgt_valid, response err=1, rdata=0, o_err_cnt=1.
- Issue SRAMC read, then SRAMA read. SRAMA responds first -> o_tgt_rsp_ready[1]=0 until the SRAMC response pops, then the SRAMA data is returned second.
- Issue 5 requests to SRAMB with no responses -> o_req_ready=0 on the 5th (count=4). One response pop -> 5th is accepted the next cycle, not the same cycle.
- Address 0x0010_0000 and address 0x0005_0000 -> both ERR. Drive 300 ERR requests -> o_err_cnt saturates at 255.
- Assert i_rst with 3 outstanding -> o_rsp_valid=0 immediately, count=0, o_err_cnt=0. A fresh request is accepted and routed correctly after deassertion.
